// File: rtl/gate_pkg.sv
// Shared types and default timing for the parking-gate direction decoder.
package gate_pkg;

    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int TIMEOUT_DEFAULT  = 200000000;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        EN1        = 4'd1,
        EN2        = 4'd2,
        EN3        = 4'd3,
        EX1        = 4'd4,
        EX2        = 4'd5,
        EX3        = 4'd6,
        WAIT_CLEAR = 4'd7,
        FAULT      = 4'd8
    } state_t;

    // States in which a crossing is in progress and the dwell timer runs.
    function automatic logic is_tracking(input state_t s);
        return (s == EN1) || (s == EN2) || (s == EN3) ||
               (s == EX1) || (s == EX2) || (s == EX3);
    endfunction

endpackage

// File: rtl/beam_filter.sv
// Two-flop synchroniser plus stability filter for one raw beam-break input.
module beam_filter
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            count    <= '0;
            filtered <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // Count consecutive cycles of disagreement; any return to agreement restarts it.
            if (sync_p1 == filtered) begin
                count <= '0;
            end else if (count == COUNT_LAST) begin
                filtered <= sync_p1;
                count    <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gate_direction_decoder.sv
// Turns two raw gate beams into single-cycle entry/exit pulses by tracking crossing order.
module gate_direction_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic beam_a,
    input  logic beam_b,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic busy,
    output logic fault
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          a;
    logic          b;
    logic [1:0]    ab;
    logic [1:0]    ba;
    state_t        state;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic          nxt_entry;
    logic          nxt_exit;

    beam_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_a (
        .clk      (clk),
        .reset    (reset),
        .raw      (beam_a),
        .filtered (a)
    );

    beam_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_b (
        .clk      (clk),
        .reset    (reset),
        .raw      (beam_b),
        .filtered (b)
    );

    assign ab = {a, b};
    assign ba = {b, a};

    // Exit states reuse the entry table on the swapped pair.
    always_comb begin
        nxt       = state;
        nxt_entry = 1'b0;
        nxt_exit  = 1'b0;
        case (state)
            IDLE: begin
                case (ab)
                    2'b10:   nxt = EN1;
                    2'b01:   nxt = EX1;
                    2'b11:   nxt = WAIT_CLEAR;
                    default: nxt = IDLE;
                endcase
            end
            EN1: begin
                case (ab)
                    2'b11:   nxt = EN2;
                    2'b00:   nxt = IDLE;
                    2'b01:   nxt = WAIT_CLEAR;
                    default: nxt = EN1;
                endcase
            end
            EN2: begin
                case (ab)
                    2'b01:   nxt = EN3;
                    2'b10:   nxt = EN1;
                    2'b00:   nxt = WAIT_CLEAR;
                    default: nxt = EN2;
                endcase
            end
            EN3: begin
                case (ab)
                    2'b00:   begin nxt = IDLE; nxt_entry = 1'b1; end
                    2'b11:   nxt = EN2;
                    2'b10:   nxt = WAIT_CLEAR;
                    default: nxt = EN3;
                endcase
            end
            EX1: begin
                case (ba)
                    2'b11:   nxt = EX2;
                    2'b00:   nxt = IDLE;
                    2'b01:   nxt = WAIT_CLEAR;
                    default: nxt = EX1;
                endcase
            end
            EX2: begin
                case (ba)
                    2'b01:   nxt = EX3;
                    2'b10:   nxt = EX1;
                    2'b00:   nxt = WAIT_CLEAR;
                    default: nxt = EX2;
                endcase
            end
            EX3: begin
                case (ba)
                    2'b00:   begin nxt = IDLE; nxt_exit = 1'b1; end
                    2'b11:   nxt = EX2;
                    2'b10:   nxt = WAIT_CLEAR;
                    default: nxt = EX3;
                endcase
            end
            WAIT_CLEAR, FAULT: begin
                if (ab == 2'b00) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (is_tracking(state) && (timer == TIMER_LAST)) begin
            nxt       = FAULT;
            nxt_entry = 1'b0;
            nxt_exit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= nxt;
            entry_pulse <= nxt_entry;
            exit_pulse  <= nxt_exit;
            busy        <= (nxt != IDLE);
            fault       <= (nxt == FAULT);
            if ((nxt != state) || !is_tracking(state)) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_direction_decoder.sv
// Directed bench for gate_direction_decoder with short debounce and timeout settings.
module tb_gate_direction_decoder;

    logic clk;
    logic reset;
    logic beam_a;
    logic beam_b;
    logic entry_pulse;
    logic exit_pulse;
    logic busy;
    logic fault;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_entry  = 0;
    int n_exit   = 0;
    int n_both   = 0;
    int n_busy   = 0;
    int last_entry = 0;

    gate_direction_decoder #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .beam_a      (beam_a),
        .beam_b      (beam_b),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (entry_pulse === 1'b1) begin
                n_entry++;
                last_entry = cyc;
            end
            if (exit_pulse === 1'b1) n_exit++;
            if ((entry_pulse === 1'b1) && (exit_pulse === 1'b1)) n_both++;
            if (busy === 1'b1) n_busy++;
        end
    endtask

    task automatic hold(input logic va, input logic vb, input int n);
        beam_a = va;
        beam_b = vb;
        step(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int e0, x0, b0, c0;

    initial begin
        reset  = 1'b0;
        beam_a = 1'b0;
        beam_b = 1'b0;
        step(3);
        check("rst_entry", entry_pulse, 0);
        check("rst_exit", exit_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        reset = 1'b1;
        step(2);
        check("idle_busy", busy, 0);

        // Entry crossing with latency measured from the clearing edge of beam B
        e0 = n_entry; x0 = n_exit;
        hold(1, 0, 20);
        check("en_busy", busy, 1);
        hold(1, 1, 20);
        hold(0, 1, 20);
        beam_b = 1'b0;
        c0 = cyc;
        step(20);
        check("en_count", n_entry, e0 + 1);
        check("en_no_exit", n_exit, x0);
        check("en_latency", last_entry - c0, 7);
        check("en_idle", busy, 0);

        // Exit crossing followed immediately by an entry crossing
        hold(0, 1, 20);
        hold(1, 1, 20);
        hold(1, 0, 20);
        beam_a = 1'b0;
        step(7);
        check("ex_pulse", exit_pulse, 1);
        check("ex_count", n_exit, x0 + 1);
        hold(1, 0, 20);
        hold(1, 1, 20);
        hold(0, 1, 20);
        hold(0, 0, 20);
        check("b2b_entry", n_entry, e0 + 2);
        check("b2b_exit", n_exit, x0 + 1);

        // Aborted approach and backing out
        e0 = n_entry; x0 = n_exit;
        hold(1, 0, 20);
        hold(0, 0, 20);
        check("abort_busy", busy, 0);
        hold(1, 0, 20);
        hold(1, 1, 20);
        hold(1, 0, 20);
        hold(0, 0, 20);
        check("backout_entry", n_entry, e0);
        check("backout_exit", n_exit, x0);
        check("backout_busy", busy, 0);

        // Short glitches on beam A while idle
        b0 = n_busy;
        for (int g = 0; g < 3; g++) begin
            hold(1, 0, 3);
            hold(0, 0, 5);
        end
        step(10);
        check("glitch_busy", n_busy - b0, 0);

        // Bounce on beam A during the AB hold
        e0 = n_entry;
        hold(1, 0, 20);
        hold(1, 1, 10);
        hold(0, 1, 2);
        hold(1, 1, 2);
        hold(0, 1, 2);
        hold(1, 1, 20);
        hold(0, 1, 20);
        hold(0, 0, 20);
        check("bounce_entry", n_entry, e0 + 1);

        // Dwell timeout in EN1
        e0 = n_entry; x0 = n_exit;
        beam_a = 1'b1;
        c0 = cyc;
        step(6);
        check("to_pre_busy", busy, 0);
        step(1);
        check("to_en1_busy", busy, 1);
        step(49);
        check("to_pre_fault", fault, 0);
        step(1);
        check("to_fault", fault, 1);
        step(3);
        beam_a = 1'b0;
        step(6);
        check("to_fault_held", fault, 1);
        step(1);
        check("to_fault_clear", fault, 0);
        check("to_idle", busy, 0);
        check("to_no_entry", n_entry, e0);
        check("to_no_exit", n_exit, x0);

        // Reset while in EN2 discards the crossing
        e0 = n_entry;
        hold(1, 0, 20);
        hold(1, 1, 20);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        step(1);
        check("mid_rst_busy", busy, 0);
        reset = 1'b1;
        step(20);
        check("mid_wait_busy", busy, 1);
        hold(0, 1, 20);
        hold(0, 0, 20);
        check("mid_no_entry", n_entry, e0);
        check("mid_idle", busy, 0);

        check("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
